// File: rtl/dco_pkg.sv
// Shared constants and helpers for the ADPLL digitally controlled oscillator.
// Bank ranges, default FCW steps and the bank-code saturation function.
package dco_pkg;

  localparam int ACC_W_DEF = 16;
  localparam int FCW0_DEF  = 4096;

  localparam int L_MAX_DEF = 63;
  localparam int M_MAX_DEF = 255;
  localparam int S_MAX_DEF = 255;

  localparam int KL_DEF = 256;
  localparam int KM_DEF = 16;
  localparam int KS_DEF = 1;

  // Clip a signed bank code into the legal range [0, max].
  function automatic int sat_code(input int v, input int max);
    if (v < 0) begin
      return 0;
    end
    if (v > max) begin
      return max;
    end
    return v;
  endfunction

endpackage

// File: rtl/dco_phase_acc.sv
// Phase accumulator turning an FCW into the ckv square wave, plus the smp
// event toggle that flips on every ckv transition while enabled.
module dco_phase_acc #(
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [ACC_W-1:0] fcw,
  output logic             ckv,
  output logic             smp
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_next;
  logic             ckv_next;

  // Disabling parks the phase at zero so re-enable always starts from phase 0.
  always_comb begin
    acc_next = en ? (acc + fcw) : '0;
    ckv_next = acc_next[ACC_W-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      ckv <= 1'b0;
      smp <= 1'b0;
    end else begin
      acc <= acc_next;
      ckv <= ckv_next;
      // The forced ckv drop on disable is not an oscillator edge, so smp holds.
      if (en) begin
        smp <= smp ^ (ckv_next != ckv);
      end
    end
  end

endmodule

// File: rtl/adpll_dco.sv
// ADPLL DCO top: saturates the three tuning-bank codes, forms the clamped
// frequency control word and drives the phase accumulator.
module adpll_dco
  import dco_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int FCW0  = FCW0_DEF,
  parameter int KL    = KL_DEF,
  parameter int KM    = KM_DEF,
  parameter int KS    = KS_DEF,
  parameter int L_MAX = L_MAX_DEF,
  parameter int M_MAX = M_MAX_DEF,
  parameter int S_MAX = S_MAX_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic signed [31:0] dco_in_l,
  input  logic signed [31:0] dco_in_m,
  input  logic signed [31:0] dco_in_s,
  output logic               ckv,
  output logic               smp,
  output logic [ACC_W-1:0]   fcw
);

  localparam logic [31:0] FCW0_U  = FCW0;
  localparam logic [31:0] KL_U    = KL;
  localparam logic [31:0] KM_U    = KM;
  localparam logic [31:0] KS_U    = KS;
  // Keep f_ckv strictly below f_clk/2 so every ckv half-period is >= 1 clk.
  localparam logic [31:0] FCW_MAX = (32'd1 << (ACC_W - 1)) - 32'd1;

  logic [31:0]      l_q;
  logic [31:0]      m_q;
  logic [31:0]      s_q;
  logic [31:0]      fcw_sum;
  logic [ACC_W-1:0] fcw_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      l_q <= '0;
      m_q <= '0;
      s_q <= '0;
    end else begin
      l_q <= sat_code(dco_in_l, L_MAX);
      m_q <= sat_code(dco_in_m, M_MAX);
      s_q <= sat_code(dco_in_s, S_MAX);
    end
  end

  always_comb begin
    fcw_sum  = FCW0_U + (l_q * KL_U) + (m_q * KM_U) + (s_q * KS_U);
    fcw_next = (fcw_sum > FCW_MAX) ? FCW_MAX[ACC_W-1:0] : fcw_sum[ACC_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fcw <= FCW0_U[ACC_W-1:0];
    end else begin
      fcw <= fcw_next;
    end
  end

  dco_phase_acc #(
    .ACC_W (ACC_W)
  ) u_phase_acc (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .fcw (fcw),
    .ckv (ckv),
    .smp (smp)
  );

endmodule

// File: tb/tb_adpll_dco.sv
// Self-checking bench for adpll_dco: a cycle-level reference of the tuning
// pipeline and phase arithmetic, directed scenarios and random stimulus.
module tb_adpll_dco;

  logic               clk;
  logic               rst;
  logic               en;
  logic signed [31:0] dco_in_l;
  logic signed [31:0] dco_in_m;
  logic signed [31:0] dco_in_s;
  logic               ckv;
  logic               smp;
  logic [15:0]        fcw;

  int n_tests;
  int n_fail;

  // reference model state
  int ref_l, ref_m, ref_s;
  int ref_fcw;
  int ref_phase;
  bit ref_ckv, ref_smp;

  adpll_dco dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .dco_in_l (dco_in_l),
    .dco_in_m (dco_in_m),
    .dco_in_s (dco_in_s),
    .ckv      (ckv),
    .smp      (smp),
    .fcw      (fcw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int clip(input int v, input int mx);
    return (v < 0) ? 0 : ((v > mx) ? mx : v);
  endfunction

  function automatic int fcw_of(input int l, input int m, input int s);
    int f;
    f = 4096 + l * 256 + m * 16 + s;
    return (f > 32767) ? 32767 : f;
  endfunction

  // Advance one clock edge: the model consumes the inputs present before the
  // edge; each pipeline stage sees the previous value of the stage before it.
  task automatic step();
    bit r, e;
    int il, im, is_;
    bit new_ckv;
    r = rst; e = en; il = dco_in_l; im = dco_in_m; is_ = dco_in_s;
    @(posedge clk);
    #1;
    if (r) begin
      ref_l = 0; ref_m = 0; ref_s = 0;
      ref_fcw = 4096; ref_phase = 0; ref_ckv = 0; ref_smp = 0;
    end else begin
      ref_phase = e ? ((ref_phase + ref_fcw) % 65536) : 0;
      new_ckv   = (ref_phase >= 32768);
      if (e && (new_ckv != ref_ckv)) ref_smp = !ref_smp;
      ref_ckv = new_ckv;
      ref_fcw = fcw_of(ref_l, ref_m, ref_s);
      ref_l = clip(il, 63); ref_m = clip(im, 255); ref_s = clip(is_, 255);
    end
    check("model_ckv", ckv, ref_ckv);
    check("model_smp", smp, ref_smp);
    check("model_fcw", fcw, ref_fcw);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_ckv(input bit val, input int budget, output int n);
    n = 0;
    while (ckv !== val && n < budget) begin
      step();
      n++;
    end
    if (ckv !== val) check("timeout_ckv", ckv, val);
  endtask

  task automatic set_codes(input int l, input int m, input int s);
    dco_in_l = l; dco_in_m = m; dco_in_s = s;
  endtask

  int  n, hi, lo, total, bad, toggles, f, exp_first;
  bit  smp_hold, prev_smp;

  initial begin
    n_tests = 0; n_fail = 0;
    ref_l = 0; ref_m = 0; ref_s = 0; ref_fcw = 4096; ref_phase = 0;
    ref_ckv = 0; ref_smp = 0;
    rst = 1'b1; en = 1'b1;
    set_codes(0, 0, 0);
    steps(3);
    check("rst_fcw", fcw, 4096);
    check("rst_ckv", ckv, 0);
    check("rst_smp", smp, 0);

    // free-running: 16-cycle period, 8 high / 8 low, first rise after 8
    rst = 1'b0;
    wait_ckv(1, 40, n);
    check("free_first_rise", n, 8);
    for (int p = 0; p < 4; p++) begin
      wait_ckv(0, 40, hi);
      wait_ckv(1, 40, lo);
      check("free_high", hi, 8);
      check("free_low", lo, 8);
    end
    toggles = 0;
    prev_smp = smp;
    for (int i = 0; i < 32; i++) begin
      step();
      if (smp != prev_smp) toggles++;
      prev_smp = smp;
    end
    check("free_smp_toggles", toggles, 4);

    // mid-range tuning: 9584 periods fill exactly 2^16 clocks
    set_codes(13, 127, 128);
    steps(3);
    check("fcw_9584", fcw, 9584);
    wait_ckv(0, 20, n);
    wait_ckv(1, 20, n);
    total = 0; bad = 0;
    for (int p = 0; p < 9584; p++) begin
      wait_ckv(0, 20, hi);
      wait_ckv(1, 20, lo);
      total += hi + lo;
      if ((hi + lo) != 6 && (hi + lo) != 7) bad++;
    end
    check("dither_total", total, 65536);
    check("dither_bad_periods", bad, 0);

    // saturation of out-of-range codes, two-cycle fcw latency
    set_codes(100, -5, 300);
    step();
    check("sat_fcw_lat1", fcw, 9584);
    step();
    check("sat_fcw_lat2", fcw, 20479);
    steps(20);

    // enable drop mid-period, then re-enable from phase 0
    set_codes(13, 127, 128);
    steps(4);
    wait_ckv(1, 20, n);
    step();
    smp_hold = smp;
    en = 1'b0;
    step();
    check("dis_ckv", ckv, 0);
    for (int i = 0; i < 10; i++) begin
      step();
      check("dis_ckv_low", ckv, 0);
      check("dis_smp_frozen", smp, smp_hold);
    end
    en = 1'b1;
    f = fcw;
    exp_first = (32768 + 9584 - 1) / 9584;
    check("reen_fcw", f, 9584);
    wait_ckv(1, 40, n);
    check("reen_first_rise", n, exp_first);

    // reset while running
    steps(5);
    n = 0;
    while (smp !== 1'b1 && n < 40) begin step(); n++; end
    check("pre_rst_smp", smp, 1);
    rst = 1'b1;
    step();
    check("run_rst_ckv", ckv, 0);
    check("run_rst_smp", smp, 0);
    check("run_rst_fcw", fcw, 4096);
    rst = 1'b0;
    set_codes(0, 0, 0);
    steps(13);

    // small-bank step, phase continuity tracked by the per-cycle model
    set_codes(0, 0, 255);
    step();
    check("step_fcw_n1", fcw, 4096);
    step();
    check("step_fcw_n2", fcw, 4351);
    steps(40);

    // random codes, enable and occasional reset against the model
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0)
        set_codes(int'($urandom_range(0, 120)) - 20,
                  int'($urandom_range(0, 340)) - 40,
                  int'($urandom_range(0, 340)) - 40);
      if ($urandom_range(0, 49) == 0) en = ~en;
      rst = ($urandom_range(0, 299) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
